temporal_min_n: RTL and testbench
=================================

// Module: temporal_min_n
// PURPOSE
//  N-input temporal minimum for race-logic datapaths. Each gamma cycle it measures a
//  value per enabled channel, either as first-arrival time (EDGE) or as high time (PULSE).
//  At gamma-cycle end it reports the minimum value and the winning channel index, and
//  replays the minimum as a temporal waveform on y during the next gamma cycle.
//  It generalises the 2-input min cell and sits between neuron columns and WTA/inhibition.
// PARAMETERS
//  N_INPUTS          4   number of input channels (>=2)
//  GAMMA_CYCLE_WIDTH 16  aclk cycles per gamma cycle (>=2)
//  MODE              0   0 = EDGE (first rising arrival time), 1 = PULSE (high-cycle count)
//  TW  $clog2(GAMMA_CYCLE_WIDTH+1)  width of time/width values (derived, localparam)
// PORTS
//  aclk        in   1         clock
//  grst_n      in   1         reset; synchronous, active-low
//  a           in   N_INPUTS  temporally coded inputs, sampled on posedge aclk
//  en_mask     in   N_INPUTS  1 = channel takes part in this gamma cycle
//  gamma_start out  1         high while g_cnt==0
//  y           out  1         replayed minimum (waveform per MODE)
//  min_valid   out  1         one-cycle pulse: min_val, min_idx and min_none updated
//  min_val     out  TW        minimum value; GAMMA_CYCLE_WIDTH means "no event"
//  min_idx     out  $clog2(N_INPUTS)  winning channel; lowest index on a tie
//  min_none    out  1         no enabled channel produced an event
// BEHAVIOUR
//  - g_cnt: 0..GCW-1, +1 per aclk, wraps to 0. The sample taken on the edge where
//    g_cnt==k is attributed to time k.
//  - en_mask is sampled at the g_cnt==0 edge and held for the whole gamma cycle.
//    Masked channels never win.
//  - EDGE mode, per channel: t_i starts each gamma cycle at GCW (infinity).
//    On the first sample with a[i]==1 and t_i==GCW, t_i <= g_cnt. Later samples are
//    ignored (sticky), and so is a channel already high at k=0 (t_i=0).
//  - PULSE mode, per channel: w_i starts each gamma cycle at 0 and is +1 per sample with
//    a[i]==1, saturating at GCW. A channel with w_i==0 counts as "no event" (value GCW).
//  - At the g_cnt==GCW-1 edge (that sample included): the minimum over enabled channels
//    is registered, with ties going to the lowest index. min_valid=1 for the following
//    cycle (g_cnt==0) only. Accumulators are re-initialised for the new gamma cycle.
//  - All channels masked or none fired: min_val=GCW, min_idx=0, min_none=1.
//  - Result latency: exactly GCW cycles from the first sample of a gamma cycle to
//    min_valid. Outputs hold until the next min_valid.
//  - Replay of y, once has_result is set and min_none==0:
//    EDGE: y=1 for g_cnt>=min_val through GCW-1.
//    PULSE: y=1 for g_cnt<min_val.
//    y is registered and aligned so that y=1 on the cycle g_cnt equals the threshold.
//    Otherwise y=0.
//  - Reset (grst_n==0 at a posedge): g_cnt=0, accumulators re-initialised, has_result=0,
//    y=0, min_valid=0, min_val=0, min_idx=0, min_none=0.
//    A reset mid gamma cycle discards the partial cycle: no min_valid is produced for it.
//    The first gamma cycle after reset has y=0 throughout.
// TESTING  (N_INPUTS=4, GCW=16; run with MODE=0 and MODE=1)
//  1 Reset, then a=0 for a full cycle -> min_valid at next g=0, min_val=16, min_none=1;
//    y stays 0.
//  2 EDGE: a[2] rises g=3, a[0] rises g=5, mask=1111 -> min_val=3, min_idx=2;
//    next cycle y=1 for g=3..15.
//  3 EDGE tie: a[1], a[3] rise g=4 -> min_idx=1, min_val=4.
//  4 PULSE: a[0] high g=2..9 (w=8), a[1] high g=4..5 (w=2) -> min_val=2, min_idx=1;
//    next cycle y=1 at g=0,1 only.
//  5 Mask: en_mask=1110, EDGE a[0] at g=1, a[1] at g=7 -> min_idx=1, min_val=7.
//  6 grst_n low for one edge at g=8 with events pending -> no min_valid;
//    g_cnt restarts at 0; outputs read reset values.

Source files
------------

// File: rtl/temporal_min_n.sv
// temporal_min_n
//   N-input temporal minimum for race-logic datapaths. A free-running gamma
//   counter divides time into gamma cycles of GAMMA_CYCLE_WIDTH aclk cycles.
//   In each gamma cycle, every enabled channel is measured in one of two ways:
//   MODE 0 (EDGE) records the time of the first rising arrival, and
//   MODE 1 (PULSE) counts the cycles for which the channel is high.
//   At the end of the gamma cycle the block reports the minimum value and the
//   index of the winning channel. During the next gamma cycle it replays that
//   minimum as a waveform on y.
// Ports
//   aclk        clock
//   grst_n      synchronous active-low reset
//   a           temporally coded inputs, one bit per channel
//   en_mask     per-channel enable, sampled when g_cnt==0
//   gamma_start high while g_cnt==0
//   y           replayed minimum (EDGE: high from min_val to end; PULSE: high for min_val cycles)
//   min_valid   one-cycle pulse when min_val/min_idx/min_none update
//   min_val     minimum value; GAMMA_CYCLE_WIDTH means no event
//   min_idx     winning channel, lowest index on a tie
//   min_none    no enabled channel produced an event
module temporal_min_n #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int MODE              = 0,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH + 1),
  localparam int IW = $clog2(N_INPUTS)
) (
  input  logic                aclk,
  input  logic                grst_n,
  input  logic [N_INPUTS-1:0] a,
  input  logic [N_INPUTS-1:0] en_mask,
  output logic                gamma_start,
  output logic                y,
  output logic                min_valid,
  output logic [TW-1:0]       min_val,
  output logic [IW-1:0]       min_idx,
  output logic                min_none
);

  localparam logic [TW-1:0] GCW  = TW'(GAMMA_CYCLE_WIDTH);
  localparam logic [TW-1:0] LAST = TW'(GAMMA_CYCLE_WIDTH - 1);

  logic [TW-1:0]       g_cnt_q, g_cnt_d;
  logic [N_INPUTS-1:0] mask_q, mask_d;
  logic [TW-1:0]       acc_q [N_INPUTS];
  logic [TW-1:0]       acc_d [N_INPUTS];
  logic [TW-1:0]       val_c [N_INPUTS];
  logic                has_result_q, has_result_d;
  logic                valid_q, valid_d;
  logic [TW-1:0]       min_val_q, min_val_d;
  logic [IW-1:0]       min_idx_q, min_idx_d;
  logic                none_q, none_d;
  logic                y_q, y_d;

  logic                first_s, last_s;
  logic [TW-1:0]       base;
  logic [TW-1:0]       best_val;
  logic [IW-1:0]       best_idx;

  always_comb begin
    first_s  = (g_cnt_q == '0);
    last_s   = (g_cnt_q == LAST);
    g_cnt_d  = last_s ? '0 : g_cnt_q + 1'b1;
    mask_d   = first_s ? en_mask : mask_q;
    base     = '0;
    best_val = GCW;
    best_idx = '0;

    // The sample at g_cnt==0 lands on a freshly initialised accumulator, so a
    // channel that is already high at k=0 gets t=0 (EDGE) or w=1 (PULSE).
    for (int i = 0; i < N_INPUTS; i++) begin
      if (MODE == 0) begin
        base     = first_s ? GCW : acc_q[i];
        acc_d[i] = (a[i] && (base == GCW)) ? g_cnt_q : base;
        val_c[i] = acc_d[i];
      end else begin
        base     = first_s ? '0 : acc_q[i];
        acc_d[i] = (a[i] && (base != GCW)) ? base + 1'b1 : base;
        val_c[i] = (acc_d[i] == '0) ? GCW : acc_d[i];
      end
    end

    // Strict less-than while scanning upward keeps the lowest index on a tie.
    for (int i = 0; i < N_INPUTS; i++) begin
      if (mask_d[i] && (val_c[i] < best_val)) begin
        best_val = val_c[i];
        best_idx = IW'(i);
      end
    end

    valid_d      = last_s;
    has_result_d = has_result_q | last_s;
    min_val_d    = last_s ? best_val : min_val_q;
    min_idx_d    = last_s ? best_idx : min_idx_q;
    none_d       = last_s ? (best_val == GCW) : none_q;

    // y is registered, so it is computed from the next counter value and the
    // next result. This way, y is valid in the cycle where g_cnt hits the threshold.
    if (MODE == 0) begin
      y_d = has_result_d && !none_d && (g_cnt_d >= min_val_d);
    end else begin
      y_d = has_result_d && !none_d && (g_cnt_d < min_val_d);
    end
  end

  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      g_cnt_q      <= '0;
      mask_q       <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        acc_q[i] <= (MODE == 0) ? GCW : '0;
      end
      has_result_q <= 1'b0;
      valid_q      <= 1'b0;
      min_val_q    <= '0;
      min_idx_q    <= '0;
      none_q       <= 1'b0;
      y_q          <= 1'b0;
    end else begin
      g_cnt_q      <= g_cnt_d;
      mask_q       <= mask_d;
      for (int i = 0; i < N_INPUTS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      has_result_q <= has_result_d;
      valid_q      <= valid_d;
      min_val_q    <= min_val_d;
      min_idx_q    <= min_idx_d;
      none_q       <= none_d;
      y_q          <= y_d;
    end
  end

  assign gamma_start = first_s;
  assign y           = y_q;
  assign min_valid   = valid_q;
  assign min_val     = min_val_q;
  assign min_idx     = min_idx_q;
  assign min_none    = none_q;

endmodule

// File: tb/tb_temporal_min_n.sv
module tb_temporal_min_n;
  localparam int N   = 4;
  localparam int GCW = 16;
  localparam int TW  = 5;
  localparam int IW  = 2;
  localparam int NV  = 8;

  logic          aclk = 1'b0;
  logic          grst_n = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  en_mask = '0;

  logic          gs_e, y_e, mv_e, none_e;
  logic [TW-1:0] val_e;
  logic [IW-1:0] idx_e;
  logic          gs_p, y_p, mv_p, none_p;
  logic [TW-1:0] val_p;
  logic [IW-1:0] idx_p;

  temporal_min_n #(.N_INPUTS(N), .GAMMA_CYCLE_WIDTH(GCW), .MODE(0)) dut_e (
    .aclk(aclk), .grst_n(grst_n), .a(a), .en_mask(en_mask),
    .gamma_start(gs_e), .y(y_e), .min_valid(mv_e),
    .min_val(val_e), .min_idx(idx_e), .min_none(none_e)
  );

  temporal_min_n #(.N_INPUTS(N), .GAMMA_CYCLE_WIDTH(GCW), .MODE(1)) dut_p (
    .aclk(aclk), .grst_n(grst_n), .a(a), .en_mask(en_mask),
    .gamma_start(gs_p), .y(y_p), .min_valid(mv_p),
    .min_val(val_p), .min_idx(idx_p), .min_none(none_p)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: it records the raw samples of each gamma cycle and
  // evaluates the result from the recorded sample window at the end of the cycle.
  int          m_g;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_samp [GCW];
  bit          m_has, m_valid;
  int          m_val [2];
  int          m_idx [2];
  bit          m_none [2];
  int          m_bv, m_bi, m_v;

  function automatic int chan_value(int md, int ch);
    int first_t = GCW;
    int cnt = 0;
    for (int k = 0; k < GCW; k++) begin
      if (m_samp[k][ch] === 1'b1) begin
        if (first_t == GCW) first_t = k;
        cnt++;
      end
    end
    if (md == 0) return first_t;
    return (cnt == 0) ? GCW : cnt;
  endfunction

  always @(posedge aclk) begin
    if (!grst_n) begin
      m_g = 0; m_has = 0; m_valid = 0;
      for (int md = 0; md < 2; md++) begin
        m_val[md] = 0; m_idx[md] = 0; m_none[md] = 0;
      end
    end else begin
      if (m_g == 0) m_mask = en_mask;
      m_samp[m_g] = a;
      m_valid = 0;
      if (m_g == GCW - 1) begin
        for (int md = 0; md < 2; md++) begin
          m_bv = GCW; m_bi = 0;
          for (int i = 0; i < N; i++) begin
            if (m_mask[i]) begin
              m_v = chan_value(md, i);
              if (m_v < m_bv) begin m_bv = m_v; m_bi = i; end
            end
          end
          m_val[md] = m_bv; m_idx[md] = m_bi; m_none[md] = (m_bv == GCW);
        end
        m_has = 1; m_valid = 1;
      end
      m_g = (m_g + 1) % GCW;
    end
  end

  function automatic logic exp_y(int md);
    if (!m_has || m_none[md]) return 1'b0;
    if (md == 0) return (m_g >= m_val[md]);
    return (m_g < m_val[md]);
  endfunction

  task automatic check_all();
    chk("gamma_start_e", 32'(gs_e), 32'(m_g == 0));
    chk("gamma_start_p", 32'(gs_p), 32'(m_g == 0));
    chk("min_valid_e", 32'(mv_e), 32'(m_valid));
    chk("min_valid_p", 32'(mv_p), 32'(m_valid));
    chk("min_val_e", 32'(val_e), 32'(m_val[0]));
    chk("min_val_p", 32'(val_p), 32'(m_val[1]));
    chk("min_idx_e", 32'(idx_e), 32'(m_idx[0]));
    chk("min_idx_p", 32'(idx_p), 32'(m_idx[1]));
    chk("min_none_e", 32'(none_e), 32'(m_none[0]));
    chk("min_none_p", 32'(none_p), 32'(m_none[1]));
    chk("y_e", 32'(y_e), 32'(exp_y(0)));
    chk("y_p", 32'(y_p), 32'(exp_y(1)));
  endtask

  // Checks the current cycle and then drives the inputs for the next posedge.
  task automatic cycle(input logic [N-1:0] av, input logic [N-1:0] mv, input logic rv);
    @(negedge aclk);
    check_all();
    a = av; en_mask = mv; grst_n = rv;
  endtask

  typedef struct packed {
    logic [N-1:0]      mask;
    logic [N-1:0][4:0] rise;
    logic [N-1:0][4:0] len;
    logic [4:0]        ev;
    logic [1:0]        ei;
    logic [4:0]        pv;
    logic [1:0]        pi;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic [3:0] m, logic [19:0] r, logic [19:0] l,
                              int ev, int ei, int pv, int pi);
    vec_t v;
    v.mask = m; v.rise = r; v.len = l;
    v.ev = 5'(ev); v.ei = 2'(ei); v.pv = 5'(pv); v.pi = 2'(pi);
    return v;
  endfunction

  function automatic logic [N-1:0] wave(vec_t v, int g);
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++)
      r[i] = (g >= int'(v.rise[i])) && (g < int'(v.rise[i]) + int'(v.len[i]));
    return r;
  endfunction

  vec_t         prv;
  bit           prv_ok;
  logic [N-1:0] av;

  initial begin
    // rise/len are packed {ch3,ch2,ch1,ch0}
    vecs[0] = mk(4'hF, {5'd16,5'd16,5'd16,5'd16}, {5'd0,5'd0,5'd0,5'd0},    16,0,16,0);
    vecs[1] = mk(4'hF, {5'd16,5'd3,5'd16,5'd5},   {5'd0,5'd13,5'd0,5'd11},  3,2,11,0);
    vecs[2] = mk(4'hF, {5'd4,5'd16,5'd4,5'd16},   {5'd2,5'd0,5'd2,5'd0},    4,1,2,1);
    vecs[3] = mk(4'hF, {5'd16,5'd16,5'd4,5'd2},   {5'd0,5'd0,5'd2,5'd8},    2,0,2,1);
    vecs[4] = mk(4'hE, {5'd16,5'd16,5'd7,5'd1},   {5'd0,5'd0,5'd1,5'd3},    7,1,1,1);
    vecs[5] = mk(4'hF, {5'd16,5'd16,5'd0,5'd0},   {5'd0,5'd0,5'd1,5'd16},   0,0,1,1);
    vecs[6] = mk(4'hF, {5'd15,5'd16,5'd16,5'd16}, {5'd1,5'd0,5'd0,5'd0},    15,3,1,3);
    vecs[7] = mk(4'h0, {5'd0,5'd0,5'd0,5'd0},     {5'd16,5'd16,5'd16,5'd16},16,0,16,0);

    for (int i = 0; i < 3; i++) cycle('0, '0, 1'b0);

    // Directed gamma cycles. While one record is applied, the previous
    // record's result and replay are checked against its constant expectations.
    prv_ok = 0;
    prv = vecs[0];
    for (int r = 0; r <= NV; r++) begin
      for (int g = 0; g < GCW; g++) begin
        av = (r < NV) ? wave(vecs[r], g) : '0;
        cycle(av, (r < NV) ? vecs[r].mask : 4'hF, 1'b1);
        if (!prv_ok) begin
          chk("tbl_y_e_first", 32'(y_e), 32'(0));
          chk("tbl_y_p_first", 32'(y_p), 32'(0));
          if (g == 0) chk("tbl_valid_first", 32'(mv_e), 32'(0));
        end else begin
          chk("tbl_y_e", 32'(y_e), 32'((prv.ev != 16) && (g >= int'(prv.ev))));
          chk("tbl_y_p", 32'(y_p), 32'((prv.pv != 16) && (g < int'(prv.pv))));
          if (g == 0) begin
            chk("tbl_valid_e", 32'(mv_e), 32'(1));
            chk("tbl_valid_p", 32'(mv_p), 32'(1));
            chk("tbl_val_e", 32'(val_e), 32'(prv.ev));
            chk("tbl_idx_e", 32'(idx_e), 32'(prv.ei));
            chk("tbl_none_e", 32'(none_e), 32'(prv.ev == 16));
            chk("tbl_val_p", 32'(val_p), 32'(prv.pv));
            chk("tbl_idx_p", 32'(idx_p), 32'(prv.pi));
            chk("tbl_none_p", 32'(none_p), 32'(prv.pv == 16));
          end else begin
            chk("tbl_valid_off", 32'(mv_e | mv_p), 32'(0));
          end
        end
      end
      if (r < NV) begin prv = vecs[r]; prv_ok = 1; end
    end

    // Randomized gamma cycles with sparse activity and a fresh mask per cycle.
    for (int c = 0; c < 30; c++) begin
      logic [N-1:0] rm;
      rm = N'($urandom);
      for (int g = 0; g < GCW; g++)
        cycle(N'($urandom & $urandom & $urandom), rm, 1'b1);
    end

    // Reset at the g=8 edge, with events already captured in this gamma cycle.
    for (int g = 0; g < 8; g++) cycle(4'b0110, 4'hF, 1'b1);
    cycle(4'b0110, 4'hF, 1'b0);
    @(negedge aclk);
    chk("rst_gamma_start", 32'(gs_e & gs_p), 32'(1));
    chk("rst_valid", 32'(mv_e | mv_p), 32'(0));
    chk("rst_val_e", 32'(val_e), 32'(0));
    chk("rst_val_p", 32'(val_p), 32'(0));
    chk("rst_idx", 32'(idx_e | idx_p), 32'(0));
    chk("rst_none", 32'(none_e | none_p), 32'(0));
    chk("rst_y", 32'(y_e | y_p), 32'(0));
    a = 4'b0110; grst_n = 1'b1;
    for (int g = 1; g < GCW; g++) begin
      cycle(4'b0001, 4'hF, 1'b1);
      chk("rst_no_valid", 32'(mv_e | mv_p), 32'(0));
      chk("rst_y_quiet", 32'(y_e | y_p), 32'(0));
    end
    for (int g = 0; g < GCW + 2; g++) cycle('0, 4'hF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
